// File: rtl/bus6502_mailbox_target.sv
// 6502/6510-style bus responder exposing a host<->CPU mailbox.
// An 8-byte window at BASE holds DATA/STATUS/CTRL/COUNT. Two FIFOs carry
// bytes in each direction. DATA reads of an empty in-FIFO can stall the CPU
// through RDY, bounded by TIMEOUT PH2 cycles, and IRQn flags pending data.
module bus6502_mailbox_target #(
  parameter logic [15:0] BASE    = 16'hD000,
  parameter int          DEPTH   = 4,
  parameter int          TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        phi2,
  input  logic        rwn,
  input  logic [15:0] addr,
  input  logic [7:0]  d_i,
  output logic [7:0]  d_o,
  output logic        d_oe,
  output logic        rdy,
  output logic        irqn,
  input  logic [7:0]  h_wdata,
  input  logic        h_wvalid,
  output logic        h_wready,
  output logic [7:0]  h_rdata,
  output logic        h_rvalid,
  input  logic        h_rready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);
  localparam logic [PW-1:0] FIFO_FULL = PW'(DEPTH);

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_COUNT  = 3'd3;

  // Bus phase tracking and captured access
  logic       phi2_q;
  logic       rise, fall;
  logic       sel_now;
  logic       acc_sel, acc_rwn;
  logic [2:0] acc_reg;

  // Control / status state
  logic          irq_en, wait_en;
  logic          tmo, ovf;
  logic          stall, timed_out;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_cnt_inc;
  logic          tmo_hit;
  logic          stall_trig;

  // FIFOs: in = host -> CPU, out = CPU -> host
  logic [7:0]    in_mem  [DEPTH];
  logic [7:0]    out_mem [DEPTH];
  logic [PW-1:0] in_wptr, in_rptr, out_wptr, out_rptr;
  logic [PW-1:0] in_count, out_count;
  logic          in_empty, in_full, out_empty, out_full;
  logic          h_push, h_pop, cpu_pop_in, cpu_push_out;
  logic          cpu_wr, cpu_rd;
  logic          irq_pending;

  logic [2:0] rd_idx;
  logic [7:0] rd_data;
  logic       rd_live;

  assign rise    = phi2 & ~phi2_q;
  assign fall    = ~phi2 & phi2_q;
  assign sel_now = (addr[15:3] == BASE[15:3]);

  assign in_count  = in_wptr - in_rptr;
  assign out_count = out_wptr - out_rptr;
  assign in_empty  = (in_count == '0);
  assign in_full   = (in_count == FIFO_FULL);
  assign out_empty = (out_count == '0);
  assign out_full  = (out_count == FIFO_FULL);

  assign rdy         = ~stall;
  assign irq_pending = irq_en & ~in_empty;

  // Side effects only in a completed (rdy = 1) cycle at PH2 fall
  assign cpu_wr       = fall & acc_sel & ~acc_rwn & ~stall;
  assign cpu_rd       = fall & acc_sel & acc_rwn & ~stall;
  assign cpu_pop_in   = cpu_rd & (acc_reg == REG_DATA) & ~in_empty;
  assign cpu_push_out = cpu_wr & (acc_reg == REG_DATA) & ~out_full;
  assign h_push       = h_wvalid & ~in_full;
  assign h_pop        = h_rready & ~out_empty;

  assign stall_cnt_inc = stall_cnt + 1'b1;
  assign tmo_hit       = stall & in_empty & fall & (stall_cnt_inc == TMO_LIMIT);
  assign stall_trig    = rise & sel_now & rwn & (addr[2:0] == REG_DATA) & wait_en
                         & in_empty & ~stall & ~timed_out;

  assign h_wready = ~in_full;
  assign h_rvalid = ~out_empty;
  assign h_rdata  = out_mem[out_rptr[AW-1:0]];

  // Register read mux; at the rise clk the address is used directly
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_idx  = rise ? addr[2:0] : acc_reg;
    rd_live = rise ? (sel_now & rwn) : (phi2 & phi2_q & acc_sel & acc_rwn);
    rd_data = 8'h00;
    case (rd_idx)
      REG_DATA:   rd_data = in_empty ? 8'h00 : in_mem[in_rptr[AW-1:0]];
      REG_STATUS: rd_data = {irq_pending, 1'b0, ovf, tmo, out_empty, in_full, out_full, ~in_empty};
      REG_CTRL:   rd_data = {6'b0, wait_en, irq_en};
      REG_COUNT:  rd_data = 8'(in_count);
      default:    rd_data = 8'h00;
    endcase
  end

  // PH2 edge detector
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) phi2_q <= 1'b0;
    else        phi2_q <= phi2;
  end

  // Capture select, register index and direction at PH2 rise
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      acc_sel <= 1'b0;
      acc_reg <= 3'd0;
      acc_rwn <= 1'b1;
    end else if (rise) begin
      acc_sel <= sel_now;
      acc_reg <= addr[2:0];
      acc_rwn <= rwn;
    end
  end

  // Read data path: drive from rise+1 clk to fall+1 clk for selected reads
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      d_oe <= 1'b0;
      d_o  <= 8'h00;
    end else begin
      if (rise)      d_oe <= sel_now & rwn;
      else if (fall) d_oe <= 1'b0;
      if (rd_live)   d_o  <= rd_data;
    end
  end

  // RDY stall control with bounded wait; a timed-out read completes once with 0x00
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall     <= 1'b0;
      stall_cnt <= '0;
      timed_out <= 1'b0;
    end else if (stall_trig) begin
      stall     <= 1'b1;
      stall_cnt <= '0;
    end else if (stall) begin
      if (!in_empty) begin
        stall <= 1'b0;
      end else if (fall) begin
        stall_cnt <= stall_cnt_inc;
        if (stall_cnt_inc == TMO_LIMIT) begin
          stall     <= 1'b0;
          timed_out <= 1'b1;
        end
      end
    end else if (fall) begin
      timed_out <= 1'b0;
    end
  end

  // CTRL register and sticky TMO / OVF flags
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      irq_en  <= 1'b0;
      wait_en <= 1'b0;
      tmo     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (cpu_wr && acc_reg == REG_CTRL) begin
        irq_en  <= d_i[0];
        wait_en <= d_i[1];
      end
      if (tmo_hit)                                          tmo <= 1'b1;
      else if (cpu_wr && acc_reg == REG_STATUS && d_i[4])   tmo <= 1'b0;
      if (cpu_wr && acc_reg == REG_DATA && out_full)        ovf <= 1'b1;
      else if (cpu_wr && acc_reg == REG_STATUS && d_i[5])   ovf <= 1'b0;
    end
  end

  // Registered interrupt output
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) irqn <= 1'b1;
    else        irqn <= ~irq_pending;
  end

  // FIFO pointers; push and pop in the same clk both take effect
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      in_wptr  <= '0;
      in_rptr  <= '0;
      out_wptr <= '0;
      out_rptr <= '0;
    end else begin
      if (h_push)       in_wptr  <= in_wptr + 1'b1;
      if (cpu_pop_in)   in_rptr  <= in_rptr + 1'b1;
      if (cpu_push_out) out_wptr <= out_wptr + 1'b1;
      if (h_pop)        out_rptr <= out_rptr + 1'b1;
    end
  end

  // FIFO storage writes
  // NOTE: storage arrays are not reset; pointers alone define valid contents.
  always_ff @(posedge clk_i) begin
    if (h_push)       in_mem[in_wptr[AW-1:0]]   <= h_wdata;
    if (cpu_push_out) out_mem[out_wptr[AW-1:0]] <= d_i;
  end

endmodule

// File: tb/tb_bus6502_mailbox_target.sv
// Directed bench for bus6502_mailbox_target: FIFO transfer, overflow,
// RDY wait states with data arrival and timeout, interrupt, unmapped
// registers and asynchronous reset during a stalled read.
module tb_bus6502_mailbox_target;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        phi2;
  logic        rwn;
  logic [15:0] addr;
  logic [7:0]  d_i;
  logic [7:0]  d_o;
  logic        d_oe;
  logic        rdy;
  logic        irqn;
  logic [7:0]  h_wdata;
  logic        h_wvalid;
  logic        h_wready;
  logic [7:0]  h_rdata;
  logic        h_rvalid;
  logic        h_rready;

  int checks = 0;
  int errors = 0;

  bus6502_mailbox_target #(.BASE(16'hD000), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .phi2     (phi2),
    .rwn      (rwn),
    .addr     (addr),
    .d_i      (d_i),
    .d_o      (d_o),
    .d_oe     (d_oe),
    .rdy      (rdy),
    .irqn     (irqn),
    .h_wdata  (h_wdata),
    .h_wvalid (h_wvalid),
    .h_wready (h_wready),
    .h_rdata  (h_rdata),
    .h_rvalid (h_rvalid),
    .h_rready (h_rready)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One PH2 cycle: 3 clks low, 3 clks high. Called and returns at a clk negedge.
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           output logic [7:0] rd, output logic rdy_s,
                           output logic oe_hi, output logic oe_lo);
    addr = a; rwn = rw; d_i = wd;
    repeat (2) @(negedge clk_i);
    phi2 = 1'b1;
    repeat (3) @(negedge clk_i);
    rd = d_o; rdy_s = rdy; oe_hi = d_oe;
    phi2 = 1'b0;
    @(negedge clk_i);
    oe_lo = d_oe;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] wd);
    logic [7:0] rd;
    logic r, oh, ol;
    bus_cycle(a, 1'b0, wd, rd, r, oh, ol);
  endtask

  // Repeats the read while rdy was low at PH2 fall; bounded
  task automatic cpu_read(input logic [15:0] a, output logic [7:0] data, output int stalls,
                          output logic oe_hi, output logic oe_lo);
    logic r;
    logic done;
    stalls = 0;
    done = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 40 && !done; i++) begin
      bus_cycle(a, 1'b1, 8'h00, data, r, oe_hi, oe_lo);
      if (r) done = 1'b1;
      else   stalls++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_bound: addr %h still stalled after %0d cycles", a, stalls);
    end
  endtask

  task automatic host_push(input logic [7:0] v);
    h_wdata = v; h_wvalid = 1'b1;
    @(negedge clk_i);
    h_wvalid = 1'b0;
  endtask

  task automatic host_pop_check(input logic [7:0] exp);
    checks++;
    if ({h_rvalid, h_rdata} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL host_pop: got valid=%b data=%h exp valid=1 data=%h", h_rvalid, h_rdata, exp);
    end
    h_rready = 1'b1;
    @(negedge clk_i);
    h_rready = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] rd;
    int st;
    logic oh, ol;
    checks++;
    if ({d_oe, d_o, rdy, irqn, h_wready, h_rvalid} !== {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got oe=%b do=%h rdy=%b irqn=%b wready=%b rvalid=%b exp 0 00 1 1 1 0",
               d_oe, d_o, rdy, irqn, h_wready, h_rvalid);
    end
    cpu_read(16'hD002, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h exp 00", rd); end
    cpu_read(16'hD001, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h08) begin errors++; $display("FAIL reset_status: got %h exp 08", rd); end
  endtask

  task automatic test_fifo_read;
    logic [7:0] rd;
    int st;
    logic oh, ol;
    host_push(8'h5A);
    host_push(8'hA5);
    cpu_read(16'hD003, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h02) begin errors++; $display("FAIL count_2: got %h exp 02", rd); end
    cpu_read(16'hD000, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h5A) begin errors++; $display("FAIL data_first: got %h exp 5a", rd); end
    checks++;
    if ({oh, ol} !== 2'b10) begin errors++; $display("FAIL d_oe_window: got hi=%b lo=%b exp hi=1 lo=0", oh, ol); end
    cpu_read(16'hD003, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL count_1: got %h exp 01", rd); end
    cpu_read(16'hD000, rd, st, oh, ol);
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("FAIL data_second: got %h exp a5", rd); end
    cpu_read(16'hD003, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL count_0: got %h exp 00", rd); end
    cpu_read(16'hD000, rd, st, oh, ol);
    checks++;
    if ({rd, st} !== {8'h00, 32'd0}) begin
      errors++; $display("FAIL data_empty_nowait: got %h stalls=%0d exp 00 stalls=0", rd, st);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] rd;
    int st;
    logic oh, ol;
    for (int i = 0; i < 5; i++) cpu_write(16'hD000, 8'h11 + 8'(i));
    checks++;
    if (h_rvalid !== 1'b1) begin errors++; $display("FAIL out_rvalid: got %b exp 1", h_rvalid); end
    cpu_read(16'hD001, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h22) begin errors++; $display("FAIL status_full_ovf: got %h exp 22", rd); end
    for (int i = 0; i < 4; i++) host_pop_check(8'h11 + 8'(i));
    checks++;
    if (h_rvalid !== 1'b0) begin errors++; $display("FAIL out_drained: got rvalid=%b exp 0", h_rvalid); end
    cpu_write(16'hD001, 8'h20);
    cpu_read(16'hD001, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h08) begin errors++; $display("FAIL ovf_clear: got %h exp 08", rd); end
  endtask

  task automatic test_wait_data;
    logic [7:0] rd;
    int st;
    logic oh, ol;
    cpu_write(16'hD002, 8'h02);
    cpu_read(16'hD002, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h02) begin errors++; $display("FAIL ctrl_wait: got %h exp 02", rd); end
    fork
      cpu_read(16'hD000, rd, st, oh, ol);
      begin
        repeat (3) @(negedge phi2);
        host_push(8'h77);
      end
    join
    checks++;
    if (st !== 3) begin errors++; $display("FAIL wait_stalls: got %0d exp 3", st); end
    checks++;
    if (rd !== 8'h77) begin errors++; $display("FAIL wait_data: got %h exp 77", rd); end
    cpu_read(16'hD003, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL wait_count: got %h exp 00", rd); end
    cpu_read(16'hD001, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h08) begin errors++; $display("FAIL wait_status_no_tmo: got %h exp 08", rd); end
  endtask

  task automatic test_wait_timeout;
    logic [7:0] rd;
    int st;
    logic oh, ol;
    cpu_read(16'hD000, rd, st, oh, ol);
    checks++;
    if (st !== 15) begin errors++; $display("FAIL tmo_stalls: got %0d exp 15", st); end
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL tmo_data: got %h exp 00", rd); end
    cpu_read(16'hD001, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h18) begin errors++; $display("FAIL tmo_status: got %h exp 18", rd); end
    cpu_write(16'hD001, 8'h10);
    cpu_read(16'hD001, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h08) begin errors++; $display("FAIL tmo_clear: got %h exp 08", rd); end
  endtask

  task automatic test_irq;
    logic [7:0] rd;
    int st;
    logic oh, ol;
    cpu_write(16'hD002, 8'h01);
    h_wdata = 8'h33; h_wvalid = 1'b1;
    @(posedge clk_i); #1;
    h_wvalid = 1'b0;
    checks++;
    if (irqn !== 1'b1) begin errors++; $display("FAIL irq_latency: got irqn=%b exp 1 at push clk", irqn); end
    @(posedge clk_i); #1;
    checks++;
    if (irqn !== 1'b0) begin errors++; $display("FAIL irq_assert: got irqn=%b exp 0", irqn); end
    @(negedge clk_i);
    cpu_read(16'hD001, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h89) begin errors++; $display("FAIL irq_status: got %h exp 89", rd); end
    cpu_read(16'hD000, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h33) begin errors++; $display("FAIL irq_data: got %h exp 33", rd); end
    @(posedge clk_i); #1;
    checks++;
    if (irqn !== 1'b1) begin errors++; $display("FAIL irq_release: got irqn=%b exp 1", irqn); end
    @(negedge clk_i);
  endtask

  task automatic test_unmapped;
    logic [7:0] rd;
    int st;
    logic oh, ol;
    cpu_write(16'hD005, 8'hFF);
    cpu_read(16'hD005, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL reg5_read: got %h exp 00", rd); end
    cpu_write(16'hE002, 8'h03);
    cpu_read(16'hD002, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h01) begin errors++; $display("FAIL unselected_write: ctrl got %h exp 01", rd); end
    cpu_read(16'hE000, rd, st, oh, ol);
    checks++;
    if (oh !== 1'b0) begin errors++; $display("FAIL unselected_oe: got d_oe=%b exp 0", oh); end
  endtask

  task automatic test_reset_mid_stall;
    logic [7:0] rd;
    int st;
    logic oh, ol;
    cpu_write(16'hD002, 8'h02);
    addr = 16'hD000; rwn = 1'b1;
    repeat (2) @(negedge clk_i);
    phi2 = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({rdy, d_oe} !== 2'b01) begin errors++; $display("FAIL stall_before_reset: got rdy=%b oe=%b exp 0 1", rdy, d_oe); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy, d_oe, d_o, irqn} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b oe=%b do=%h irqn=%b exp 1 0 00 1", rdy, d_oe, d_o, irqn);
    end
    @(negedge clk_i);
    phi2 = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    cpu_read(16'hD002, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL ctrl_after_reset: got %h exp 00", rd); end
    cpu_read(16'hD003, rd, st, oh, ol);
    checks++;
    if (rd !== 8'h00) begin errors++; $display("FAIL count_after_reset: got %h exp 00", rd); end
  endtask

  initial begin
    rst_n = 1'b0; phi2 = 1'b0; rwn = 1'b1; addr = 16'h0000; d_i = 8'h00;
    h_wdata = 8'h00; h_wvalid = 1'b0; h_rready = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    test_reset;
    test_fifo_read;
    test_overflow;
    test_wait_data;
    test_wait_timeout;
    test_irq;
    test_unmapped;
    test_reset_mid_stall;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus6502_mailbox_target.md
Name: bus6502_mailbox_target

Overview:
- Memory-mapped bus responder for the 6502/6510-style initiator bus: PH2-qualified cycles, RWn, 16-bit address, 8-bit data, RDY and IRQn.
- Decodes an 8-byte window and exposes two FIFOs, one per direction, between the CPU and a host-side stream interface.
- Inserts RDY wait states when the CPU reads an empty FIFO, and raises IRQn when data is pending.
- Sits on the external bus opposite the CPU, clocked by the same clk_i that generates PH2.

Parameters:
- BASE, 16'hD000, window base address; bits [2:0] ignored.
- DEPTH, 4, entries per FIFO; power of 2, minimum 2.
- TIMEOUT, 15, maximum PH2 cycles RDY may be held low before the read is aborted.

Ports:
- clk_i  in  1  system clock, same source as the CPU PH0IN.
- rst_n  in  1  asynchronous reset, active-low.
- phi2  in  1  bus PH2, synchronous to clk_i.
- rwn  in  1  1 = read, 0 = write.
- addr  in  16  bus address.
- d_i  in  8  bus write data.
- d_o  out  8  read data.
- d_oe  out  1  data bus drive enable.
- rdy  out  1  wait request; 0 = stall.
- irqn  out  1  interrupt request, active-low.
- h_wdata  in  8  host push data into the in-FIFO (host to CPU).
- h_wvalid  in  1  host push request.
- h_wready  out  1  in-FIFO not full.
- h_rdata  out  8  out-FIFO (CPU to host) head entry.
- h_rvalid  out  1  out-FIFO not empty.
- h_rready  in  1  host pop.

Behaviour:
- **Edge detect:** phi2_q is registered. rise = phi2 & !phi2_q; fall = !phi2 & phi2_q.
- **Access capture:** at rise, latch sel = (addr[15:3] == BASE[15:3]), reg = addr[2:0], and rwn.
- **Writes:** d_i is committed at fall, only when sel, write, and rdy = 1.
- **Reads:**
  - d_o is registered. d_oe = 1 from the clk after rise until the clk after fall, only for a selected read.
  - Read side effects (FIFO pop) happen at fall, only when rdy = 1 in that cycle.
  - A cycle with rdy = 0 is a repeated cycle: no side effects, and the address is recaptured at the next rise.
- **Register map:**
  - 0 DATA. Read pops the in-FIFO; if empty and wait is disabled, return 0x00 with no pop. Write pushes the out-FIFO; if full, drop the byte and set OVF.
  - 1 STATUS (read): bit0 in_nonempty, bit1 out_full, bit2 in_full, bit3 out_empty, bit4 TMO (sticky), bit5 OVF (sticky), bit7 irq_pending, others 0. Write: a 1 in bit4 or bit5 clears that flag.
  - 2 CTRL (R/W, reset 0x00): bit0 irq_en, bit1 wait_en.
  - 3 COUNT (read-only): in-FIFO occupancy, 0..DEPTH.
  - 4-7: read 0x00; writes ignored.
- **Wait states:**
  - Trigger: selected DATA read, wait_en = 1, in-FIFO empty at rise. Then rdy = 0 from the next clk, and a stall counter is cleared.
  - Counting: at each fall while stalled, the counter increments.
  - Data arrives: if the in-FIFO becomes non-empty, rdy = 1 from the next clk. The following fall completes the read with a pop of the head byte.
  - Timeout: when the counter reaches TIMEOUT, rdy = 1, d_o = 0x00, TMO is set, and there is no pop.
  - rdy is 1 at all other times.
- **FIFOs:** circular buffers with pointers one bit wider than log2(DEPTH); wrap-around is silent.
  - A simultaneous push and pop on the same FIFO in the same clk both occur; occupancy is unchanged.
  - Host push with h_wready = 0 is ignored. Host pop with h_rvalid = 0 is ignored.
  - h_rdata shows the head entry combinationally.
- **Interrupt:** irq_pending = irq_en & in_nonempty. irqn is registered as !irq_pending, with 1 clk latency.
- **Reset (async, including mid-access):**
  - Outputs: d_oe = 0, d_o = 0x00, rdy = 1, irqn = 1, h_wready = 1, h_rvalid = 0.
  - State: FIFOs empty, CTRL = 0x00, TMO = OVF = 0, stall counter = 0.

Test Plan:
- Host pushes 0x5A and 0xA5; CPU reads D000 twice. Reads return 0x5A then 0xA5; COUNT goes 2→1→0; d_oe is high only during phi2 high.
- CPU writes 0x11..0x15 to D000 with DEPTH = 4. h_rvalid = 1; host pops 0x11..0x14; OVF set (STATUS bit5); writing 0x20 to D001 clears it.
- CTRL = 0x02, in-FIFO empty, CPU reads D000; host pushes 0x77 after 3 PH2 cycles. rdy is low for 3 cycles, read returns 0x77, COUNT = 0, TMO = 0.
- Same setup with no host push. rdy is low for exactly 15 PH2 cycles, read returns 0x00, STATUS bit4 = 1.
- CTRL = 0x01, host push. irqn falls 1 clk after the push; CPU read of DATA empties the FIFO and irqn returns to 1.
- Assert rst_n low during a stalled read. rdy = 1 and d_oe = 0 immediately; CTRL reads 0x00 after release.
